// File: rtl/aes_decryption_seq.sv
// rtl/aes_decryption_seq.sv - iterative AES-128 decryptor, one round per clock; AES_DEC_KEYCACHE_EN adds a last-key rk10 cache
module aes_decryption_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL, S_DONE
    } state_t;

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   kcnt;
    logic [3:0]   rnd;

`ifdef AES_DEC_KEYCACHE_EN
    logic         cache_valid;
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic [127:0] key_q;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // byte (r + 4c) lives at [127-8*(r+4c) -: 8]; row r rotates right by r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    logic [127:0] rk_fwd;
    logic [127:0] rk_prev;
    logic [127:0] st_core;

    assign rk_fwd  = fwd_expand(rk, rcon(kcnt));
    assign rk_prev = inv_expand(rk, rcon(rnd));
    assign st_core = inv_sub_bytes(inv_shift_rows(st)) ^ rk_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dataout   <= '0;
            st        <= '0;
            rk        <= '0;
            kcnt      <= '0;
            rnd       <= '0;
`ifdef AES_DEC_KEYCACHE_EN
            cache_valid <= 1'b0;
            cache_key   <= '0;
            cache_rk10  <= '0;
            key_q       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= datain;
                        in_ready <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
                        key_q <= key;
                        if (cache_valid && key == cache_key) begin
                            rk    <= cache_rk10;
                            state <= S_INIT;
                        end else begin
                            rk    <= key;
                            kcnt  <= 4'd1;
                            state <= S_KEYEXP;
                        end
`else
                        rk    <= key;
                        kcnt  <= 4'd1;
                        state <= S_KEYEXP;
`endif
                    end
                end
                S_KEYEXP: begin
                    rk   <= rk_fwd;
                    kcnt <= kcnt + 4'd1;
                    if (kcnt == 4'd10) begin
                        kcnt  <= 4'd0;
                        state <= S_INIT;
`ifdef AES_DEC_KEYCACHE_EN
                        cache_valid <= 1'b1;
                        cache_key   <= key_q;
                        cache_rk10  <= rk_fwd;
`endif
                    end
                end
                S_INIT: begin
                    st    <= st ^ rk;
                    rnd   <= 4'd10;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    st  <= inv_mix_columns(st_core);
                    rk  <= rk_prev;
                    rnd <= rnd - 4'd1;
                    if (rnd == 4'd2) state <= S_FINAL;
                end
                S_FINAL: begin
                    st        <= st_core;
                    rk        <= rk_prev;
                    rnd       <= 4'd0;
                    dataout   <= st_core;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decryption_seq.sv
// tb/tb_aes_decryption_seq.sv - self-checking bench for aes_decryption_seq against a forward AES-128 model
module tb_aes_decryption_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] datain;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dataout;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam int LAT_FULL = 21;
`ifdef AES_DEC_KEYCACHE_EN
    localparam int LAT_HIT = 11;
`else
    localparam int LAT_HIT = 21;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    aes_decryption_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // walks the multiplicative group with generator 3 and its inverse in lockstep
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[j+4*c] = s[j+4*((c+j)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [127:0] k, input logic [127:0] d);
        key = k;
        datain = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // counts edges from the accept edge until out_valid; -1 if it never arrives
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic do_block(input logic [127:0] k, input logic [127:0] d,
                            output logic [127:0] res, output int lat);
        send(k, d);
        wait_out(lat);
        res = dataout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dataout !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b dataout=%h, required 1 0 0", in_ready, out_valid, dataout);
        end
    endtask

    task automatic test_fips_c1();
        logic [127:0] res;
        int lat;
        do_block(K1, C1, res, lat);
        tests_run++;
        if (res !== P1) begin
            tests_failed++;
            $display("FAIL c1_data: got %h required %h", res, P1);
        end
        tests_run++;
        if (lat !== LAT_FULL) begin
            tests_failed++;
            $display("FAIL c1_latency: got %0d required %0d", lat, LAT_FULL);
        end
    endtask

    task automatic test_fips_b();
        logic [127:0] res;
        int lat;
        do_block(KB, CB, res, lat);
        tests_run++;
        if (res !== PB) begin
            tests_failed++;
            $display("FAIL appb_data: got %h required %h", res, PB);
        end
        tests_run++;
        if (lat !== LAT_FULL) begin
            tests_failed++;
            $display("FAIL appb_latency: got %0d required %0d", lat, LAT_FULL);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send(K1, C1);
        wait_out(lat);
        tests_run++;
        if (dataout !== P1 || lat < 0) begin
            tests_failed++;
            $display("FAIL bp_data: got %h required %h (lat %0d)", dataout, P1, lat);
        end
        key = KB;
        datain = CB;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dataout !== P1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b dataout=%h, required 1 0 %h", i, out_valid, in_ready, dataout, P1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        tests_run++;
        if (dataout !== P1) begin
            tests_failed++;
            $display("FAIL bp_dataout_kept: got %h required %h", dataout, P1);
        end
        repeat (30) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ignored_input: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] res;
        int lat;
        send(K1, C1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || dataout !== 128'h0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_state: out_valid=%b dataout=%h in_ready=%b, required 0 0 1", out_valid, dataout, in_ready);
        end
        rst_n = 1'b1;
        do_block(K1, C1, res, lat);
        tests_run++;
        if (res !== P1 || lat !== LAT_FULL) begin
            tests_failed++;
            $display("FAIL midreset_recover: got %h lat %0d, required %h lat %0d", res, lat, P1, LAT_FULL);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        int lat;
        apply_reset(2);
        send(K1, C1);
        wait_out(lat);
        tests_run++;
        if (dataout !== P1 || lat !== LAT_FULL) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h lat %0d, required %h lat %0d", dataout, lat, P1, LAT_FULL);
        end
        key = K1;
        datain = C1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_overlap_accept: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        tests_run++;
        if (dataout !== P1 || lat !== LAT_HIT) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h lat %0d, required %h lat %0d", dataout, lat, P1, LAT_HIT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_block(KB, CB, res, lat);
        tests_run++;
        if (res !== PB || lat !== LAT_FULL) begin
            tests_failed++;
            $display("FAIL b2b_third: got %h lat %0d, required %h lat %0d", res, lat, PB, LAT_FULL);
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] k, pt, ct, res, last_key;
        logic last_valid;
        int lat, exp_lat;
        apply_reset(2);
        last_valid = 1'b0;
        last_key = '0;
        k = '0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 3 != 2 || !last_valid)
                k = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = aes_enc(k, pt);
            exp_lat = (last_valid && k == last_key) ? LAT_HIT : LAT_FULL;
            do_block(k, ct, res, lat);
            last_valid = 1'b1;
            last_key = k;
            tests_run++;
            if (res !== pt) begin
                tests_failed++;
                $display("FAIL roundtrip_data[%0d]: key %h got %h required %h", i, k, res, pt);
            end
            tests_run++;
            if (lat !== exp_lat) begin
                tests_failed++;
                $display("FAIL roundtrip_latency[%0d]: got %0d required %0d", i, lat, exp_lat);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        key = '0;
        datain = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_roundtrip();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
